// File: rtl/tone_note_if.sv
// Sample and note-result bundle between the ADC capture side and the tone note detector.
interface tone_note_if;
    logic [7:0]  sample;
    logic        sample_valid;
    logic [2:0]  note_code;
    logic        tone_present;
    logic        note_change;
    logic [17:0] period;

    modport master (
        output sample, sample_valid,
        input  note_code, tone_present, note_change, period
    );

    modport slave (
        input  sample, sample_valid,
        output note_code, tone_present, note_change, period
    );
endinterface

// File: rtl/tone_note_detector.sv
// Measures the tone period from hysteretic midscale crossings, averages 2^AVG_LOG2 periods
// and reports a debounced melody note code (0=D4 .. 6=G5, 7=none).
module tone_note_detector #(
    parameter int unsigned MID        = 128,
    parameter int unsigned HYST       = 16,
    parameter int unsigned TIMEOUT    = 250000,
    parameter int unsigned AVG_LOG2   = 2,
    // Divides every note band edge; 1 gives the real 50 MHz bands.
    parameter int unsigned PERIOD_DIV = 1
) (
    input logic        CLOCK_50,
    input logic        reset,
    tone_note_if.slave bus
);
    localparam int unsigned CNT_W = 18;
    localparam int unsigned ACC_W = 20;
    localparam int unsigned IDX_W = AVG_LOG2;

    localparam logic [7:0]       TH_HI    = 8'(MID + HYST);
    localparam logic [7:0]       TH_LO    = 8'(MID - HYST);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
    localparam logic [2:0]       NO_NOTE  = 3'd7;

    localparam logic [CNT_W-1:0] LIM_SLOW = CNT_W'(190000 / PERIOD_DIV);
    localparam logic [CNT_W-1:0] LIM_D4   = CNT_W'(148908 / PERIOD_DIV);
    localparam logic [CNT_W-1:0] LIM_G4   = CNT_W'(120594 / PERIOD_DIV);
    localparam logic [CNT_W-1:0] LIM_A4   = CNT_W'(107438 / PERIOD_DIV);
    localparam logic [CNT_W-1:0] LIM_B4   = CNT_W'(98398 / PERIOD_DIV);
    localparam logic [CNT_W-1:0] LIM_C5   = CNT_W'(90344 / PERIOD_DIV);
    localparam logic [CNT_W-1:0] LIM_D5   = CNT_W'(74454 / PERIOD_DIV);
    localparam logic [CNT_W-1:0] LIM_G5   = CNT_W'(55000 / PERIOD_DIV);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic             measuring;
    logic [2:0]       cand;
    logic [2:0]       note_code;
    logic             tone_present;
    logic             note_change;
    logic [CNT_W-1:0] period;

    logic             timeout_c;
    logic             rise_c;
    logic [ACC_W-1:0] acc_sum_c;
    logic [CNT_W-1:0] avg_c;
    logic [2:0]       class_c;

    function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
        if (p >= LIM_SLOW)    return 3'd7;
        else if (p >= LIM_D4) return 3'd0;
        else if (p >= LIM_G4) return 3'd1;
        else if (p >= LIM_A4) return 3'd2;
        else if (p >= LIM_B4) return 3'd3;
        else if (p >= LIM_C5) return 3'd4;
        else if (p >= LIM_D5) return 3'd5;
        else if (p >= LIM_G5) return 3'd6;
        else                  return 3'd7;
    endfunction

    // Crossing FSM next state; a timeout overrides any crossing on the same cycle.
    always_comb begin
        state_nxt = state;
        rise_c    = 1'b0;
        timeout_c = (cnt == CNT_MAX);
        if (bus.sample_valid) begin
            case (state)
                ST_IDLE: if (bus.sample <= TH_LO) state_nxt = ST_LOW;
                ST_LOW: begin
                    if (bus.sample >= TH_HI) begin
                        state_nxt = ST_HIGH;
                        rise_c    = 1'b1;
                    end
                end
                ST_HIGH: if (bus.sample <= TH_LO) state_nxt = ST_LOW;
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (timeout_c) begin
            state_nxt = ST_IDLE;
            rise_c    = 1'b0;
        end
        acc_sum_c = acc + ACC_W'(cnt);
        avg_c     = CNT_W'(acc_sum_c >> AVG_LOG2);
        class_c   = classify(avg_c);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            acc          <= '0;
            idx          <= '0;
            measuring    <= 1'b0;
            cand         <= NO_NOTE;
            note_code    <= NO_NOTE;
            tone_present <= 1'b0;
            note_change  <= 1'b0;
            period       <= '0;
        end else begin
            state       <= state_nxt;
            note_change <= 1'b0;
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (timeout_c) begin
                cnt       <= '0;
                acc       <= '0;
                idx       <= '0;
                measuring <= 1'b0;
                cand      <= NO_NOTE;
                if (note_code != NO_NOTE) begin
                    note_code    <= NO_NOTE;
                    tone_present <= 1'b0;
                    note_change  <= 1'b1;
                end
            end else if (rise_c) begin
                // The crossing cycle is the first cycle of the next period.
                cnt <= CNT_W'(1);
                if (!measuring) begin
                    measuring <= 1'b1;
                    acc       <= '0;
                    idx       <= '0;
                end else if (idx == IDX_LAST) begin
                    acc    <= '0;
                    idx    <= '0;
                    period <= avg_c;
                    cand   <= class_c;
                    if (class_c == cand && class_c != note_code) begin
                        note_code    <= class_c;
                        tone_present <= (class_c != NO_NOTE);
                        note_change  <= 1'b1;
                    end
                end else begin
                    acc <= acc_sum_c;
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    assign bus.note_code    = note_code;
    assign bus.tone_present = tone_present;
    assign bus.note_change  = note_change;
    assign bus.period       = period;
endmodule

// File: tb/tb_tone_note_detector.sv
// Randomized bench for tone_note_detector with note bands scaled by DIV to keep runs short.
module tb_tone_note_detector;
    localparam int unsigned DIV   = 64;
    localparam int unsigned TO    = 250000 / DIV;
    localparam int          VSTEP = 10;
    localparam int          P_A4  = 113636 / DIV;
    localparam int          P_G5  = 63776 / DIV;
    localparam int          P_OOB = 50000 / DIV;

    logic CLOCK_50;
    logic reset;
    tone_note_if bus ();

    tone_note_detector #(.TIMEOUT(TO), .PERIOD_DIV(DIV)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int ph   = 0;
    int vph  = 0;

    // Reference model: level tracker plus crossing timestamps and a queue of periods.
    int          m_level;
    int          m_clr;
    bit          m_meas;
    int          m_q[$];
    logic [2:0]  m_cand;
    logic [2:0]  m_code;
    logic        m_change;
    logic [17:0] m_period;
    int          m_last_rise;

    function automatic logic [2:0] ref_class(input int p);
        int unsigned edges [8];
        int unsigned codes [8];
        edges = '{190000, 148908, 120594, 107438, 98398, 90344, 74454, 55000};
        codes = '{7, 0, 1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 8; i++)
            if (p >= int'(edges[i] / DIV)) return 3'(codes[i]);
        return 3'd7;
    endfunction

    task automatic model_reset();
        m_level  = 0;
        m_clr    = cyc + 1;
        m_meas   = 0;
        m_q.delete();
        m_cand   = 3'd7;
        m_code   = 3'd7;
        m_change = 1'b0;
        m_period = '0;
    endtask

    task automatic model_step(input logic [7:0] s, input logic v);
        int elapsed;
        int sum;
        bit rise;
        logic [2:0] cls;
        rise     = 0;
        m_change = 1'b0;
        elapsed  = cyc - m_clr;
        if (elapsed >= int'(TO)) begin
            m_level = 0;
            m_clr   = cyc + 1;
            m_meas  = 0;
            m_q.delete();
            m_cand  = 3'd7;
            if (m_code != 3'd7) begin
                m_code   = 3'd7;
                m_change = 1'b1;
            end
            return;
        end
        if (v && s <= 8'd112) m_level = 1;
        else if (v && s >= 8'd144 && m_level == 1) begin
            m_level = 2;
            rise    = 1;
        end
        if (!rise) return;
        m_clr       = cyc;
        m_last_rise = cyc + 1;
        if (!m_meas) begin
            m_meas = 1;
            m_q.delete();
            return;
        end
        m_q.push_back(elapsed);
        if (m_q.size() == 4) begin
            sum = 0;
            foreach (m_q[i]) sum += m_q[i];
            m_period = 18'(sum / 4);
            cls = ref_class(sum / 4);
            if (cls == m_cand && cls != m_code) begin
                m_code   = cls;
                m_change = 1'b1;
            end
            m_cand = cls;
            m_q.delete();
        end
    endtask

    task automatic cycle(input logic [7:0] s, input logic v, input logic r);
        reset            = r;
        bus.sample       = s;
        bus.sample_valid = v;
        if (r) model_reset();
        else model_step(s, v);
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    function automatic logic [7:0] wave(input int per);
        logic [7:0] s;
        s  = (ph < per / 2) ? 8'($urandom_range(0, 112)) : 8'($urandom_range(144, 255));
        ph = (ph + 1) % per;
        return s;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        vecs += 4;
        if (bus.note_code !== 3'd7) begin errs++; $display("FAIL reset_code got=%0d exp=7", bus.note_code); end
        if (bus.tone_present !== 1'b0) begin errs++; $display("FAIL reset_present got=%0d exp=0", bus.tone_present); end
        if (bus.note_change !== 1'b0) begin errs++; $display("FAIL reset_change got=%0d exp=0", bus.note_change); end
        if (bus.period !== 18'd0) begin errs++; $display("FAIL reset_period got=%0d exp=0", bus.period); end
    endtask

    task automatic test_a4_lock();
        int nchg = 0;
        int d;
        ph  = 0;
        vph = $urandom_range(0, VSTEP - 1);
        for (int i = 0; i < 10 * P_A4; i++) begin
            cycle(wave(P_A4), (cyc % VSTEP) == vph, 1'b0);
            vecs++;
            if (bus.note_code !== m_code || bus.tone_present !== (m_code != 3'd7) ||
                bus.note_change !== m_change || bus.period !== m_period) begin
                errs++;
                $display("FAIL a4_lock cyc=%0d code=%0d/%0d present=%0d chg=%0d/%0d period=%0d/%0d (got/exp)",
                         cyc, bus.note_code, m_code, bus.tone_present, bus.note_change, m_change, bus.period, m_period);
            end
            if (bus.note_change === 1'b1) nchg++;
        end
        d = int'(bus.period) - P_A4;
        vecs += 3;
        if (bus.note_code !== 3'd2 || bus.tone_present !== 1'b1) begin
            errs++; $display("FAIL a4_code got=%0d present=%0d exp=2 present=1", bus.note_code, bus.tone_present);
        end
        if (nchg != 1) begin errs++; $display("FAIL a4_change_count got=%0d exp=1", nchg); end
        if (d > 50 || d < -50) begin errs++; $display("FAIL a4_period got=%0d exp=%0d+/-50", bus.period, P_A4); end
    endtask

    task automatic test_note_switch();
        int nchg = 0;
        bit odd  = 0;
        ph  = ph % P_G5;
        vph = $urandom_range(0, VSTEP - 1);
        for (int i = 0; i < 13 * P_G5; i++) begin
            cycle(wave(P_G5), (cyc % VSTEP) == vph, 1'b0);
            vecs++;
            if (bus.note_code !== m_code || bus.tone_present !== (m_code != 3'd7) ||
                bus.note_change !== m_change || bus.period !== m_period) begin
                errs++;
                $display("FAIL note_switch cyc=%0d code=%0d/%0d present=%0d chg=%0d/%0d period=%0d/%0d (got/exp)",
                         cyc, bus.note_code, m_code, bus.tone_present, bus.note_change, m_change, bus.period, m_period);
            end
            if (bus.note_change === 1'b1) nchg++;
            if (bus.note_code !== 3'd2 && bus.note_code !== 3'd6) odd = 1;
        end
        vecs += 3;
        if (bus.note_code !== 3'd6) begin errs++; $display("FAIL g5_code got=%0d exp=6", bus.note_code); end
        if (nchg != 1) begin errs++; $display("FAIL g5_change_count got=%0d exp=1", nchg); end
        if (odd) begin errs++; $display("FAIL g5_intermediate got=1 exp=0"); end
    endtask

    task automatic test_tone_loss();
        int nchg     = 0;
        int loss_cyc = -1;
        for (int i = 0; i < int'(TO) + P_G5 + 20; i++) begin
            cycle(8'd128, 1'b1, 1'b0);
            vecs++;
            if (bus.note_code !== m_code || bus.tone_present !== (m_code != 3'd7) ||
                bus.note_change !== m_change || bus.period !== m_period) begin
                errs++;
                $display("FAIL tone_loss cyc=%0d code=%0d/%0d present=%0d chg=%0d/%0d period=%0d/%0d (got/exp)",
                         cyc, bus.note_code, m_code, bus.tone_present, bus.note_change, m_change, bus.period, m_period);
            end
            if (bus.note_change === 1'b1) begin
                nchg++;
                loss_cyc = cyc;
            end
        end
        vecs += 3;
        if (bus.note_code !== 3'd7 || bus.tone_present !== 1'b0) begin
            errs++; $display("FAIL loss_code got=%0d present=%0d exp=7 present=0", bus.note_code, bus.tone_present);
        end
        if (nchg != 1) begin errs++; $display("FAIL loss_change_count got=%0d exp=1", nchg); end
        if (loss_cyc - m_last_rise != int'(TO)) begin
            errs++; $display("FAIL loss_delay got=%0d exp=%0d", loss_cyc - m_last_rise, TO);
        end
    endtask

    task automatic test_noise();
        int nchg = 0;
        for (int i = 0; i < 5000; i++) begin
            cycle((i % 2 == 0) ? 8'd113 : 8'd143, 1'b1, 1'b0);
            vecs++;
            if (bus.note_code !== m_code || bus.tone_present !== (m_code != 3'd7) ||
                bus.note_change !== m_change || bus.period !== m_period) begin
                errs++;
                $display("FAIL noise cyc=%0d code=%0d/%0d present=%0d chg=%0d/%0d period=%0d/%0d (got/exp)",
                         cyc, bus.note_code, m_code, bus.tone_present, bus.note_change, m_change, bus.period, m_period);
            end
            if (bus.note_change === 1'b1) nchg++;
        end
        vecs += 2;
        if (bus.note_code !== 3'd7) begin errs++; $display("FAIL noise_code got=%0d exp=7", bus.note_code); end
        if (nchg != 0) begin errs++; $display("FAIL noise_change_count got=%0d exp=0", nchg); end
    endtask

    task automatic test_out_of_band();
        int nchg = 0;
        int d;
        ph  = 0;
        vph = $urandom_range(0, VSTEP - 1);
        for (int i = 0; i < 10 * P_OOB; i++) begin
            cycle(wave(P_OOB), (cyc % VSTEP) == vph, 1'b0);
            vecs++;
            if (bus.note_code !== m_code || bus.tone_present !== (m_code != 3'd7) ||
                bus.note_change !== m_change || bus.period !== m_period) begin
                errs++;
                $display("FAIL out_of_band cyc=%0d code=%0d/%0d present=%0d chg=%0d/%0d period=%0d/%0d (got/exp)",
                         cyc, bus.note_code, m_code, bus.tone_present, bus.note_change, m_change, bus.period, m_period);
            end
            if (bus.note_change === 1'b1) nchg++;
        end
        d = int'(bus.period) - P_OOB;
        vecs += 3;
        if (bus.note_code !== 3'd7) begin errs++; $display("FAIL oob_code got=%0d exp=7", bus.note_code); end
        if (nchg != 0) begin errs++; $display("FAIL oob_change_count got=%0d exp=0", nchg); end
        if (d > 50 || d < -50) begin errs++; $display("FAIL oob_period got=%0d exp=%0d+/-50", bus.period, P_OOB); end
    endtask

    task automatic test_reset_mid_window();
        int nchg = 0;
        ph  = 0;
        vph = $urandom_range(0, VSTEP - 1);
        for (int i = 0; i < 7 * P_A4 + P_A4 / 2; i++) begin
            if (i == 3 * P_A4 + P_A4 / 2) begin
                cycle(8'($urandom), 1'b1, 1'b1);
                ph = 0;
                vecs += 2;
                if (bus.period !== 18'd0) begin errs++; $display("FAIL midreset_period got=%0d exp=0", bus.period); end
                if (bus.note_code !== 3'd7) begin errs++; $display("FAIL midreset_code got=%0d exp=7", bus.note_code); end
            end else begin
                cycle(wave(P_A4), (cyc % VSTEP) == vph, 1'b0);
            end
            vecs++;
            if (bus.note_code !== m_code || bus.tone_present !== (m_code != 3'd7) ||
                bus.note_change !== m_change || bus.period !== m_period) begin
                errs++;
                $display("FAIL reset_mid cyc=%0d code=%0d/%0d present=%0d chg=%0d/%0d period=%0d/%0d (got/exp)",
                         cyc, bus.note_code, m_code, bus.tone_present, bus.note_change, m_change, bus.period, m_period);
            end
            if (bus.note_change === 1'b1) nchg++;
        end
        vecs += 2;
        if (bus.period !== 18'd0) begin errs++; $display("FAIL partial_report_period got=%0d exp=0", bus.period); end
        if (nchg != 0) begin errs++; $display("FAIL partial_report_change got=%0d exp=0", nchg); end
    endtask

    initial begin
        reset            = 1'b1;
        bus.sample       = 8'd0;
        bus.sample_valid = 1'b0;
        m_last_rise      = 0;
        model_reset();
        #1;
        test_reset();
        test_a4_lock();
        test_note_switch();
        test_tone_loss();
        test_noise();
        test_out_of_band();
        test_reset_mid_window();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
